countdown_timer: RTL
====================

Name: countdown_timer

Overview:
- Loadable down-counter: the decrementing counterpart to the lab's mod-k up-counter.
- Counts a programmed value down to zero on qualified Tick pulses and flags expiry with a one-cycle Done pulse.
- Supports pause/resume and optional auto-reload.
- Sits behind a prescaler on the DE1-SoC 50 MHz clock. Drives HEX display decode and the lab's reaction-timer/alarm logic.

Parameters:
- N, 4, counter width in bits.
- PRESET, 9, value of Q and of the reload register after reset; must satisfy PRESET < 2^N.
- AUTO_RELOAD, 0, 1 = on expiry reload and keep running; 0 = stop at zero.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Tick  in  1  count enable; one decrement per Clock edge where Tick=1 in RUN.
- Load  in  1  load D into Q and the reload register.
- D  in  N  load value.
- Start  in  1  start or resume counting.
- Stop  in  1  pause counting.
- Q  out  N  current count.
- Busy  out  1  high in RUN or HOLD.
- Done  out  1  registered one-cycle expiry pulse.

Behaviour:
Interface:
- One clock (Clock). Reset is synchronous and active-high.

Reset:
- Q=PRESET, reload register R=PRESET, state=IDLE, Busy=0, Done=0.
- Reset overrides all other inputs.

States and transitions:
- States: IDLE, RUN, HOLD, EXPIRED. Busy=1 in RUN and HOLD only (decoded from state).
- Load, any state: Q<=D, R<=D, next state IDLE, Done<=0. Load has priority over Start, Stop and Tick in the same cycle.
- Start in IDLE or HOLD:
  - Q!=0: go to RUN.
  - Q==0: go to EXPIRED, Done=1 next cycle.
- Start in EXPIRED:
  - R!=0: Q<=R, go to RUN.
  - R==0: Done pulse again, stay EXPIRED.
- Start in RUN: no effect.
- Stop in RUN: go to HOLD; Q frozen.
- Start and Stop together: Stop wins.
- Stop outside RUN: ignored.

Counting in RUN with Tick=1 (and no Load/Stop):
- Q>1: Q<=Q-1.
- Q==1, AUTO_RELOAD=0: Q<=0, go to EXPIRED, Done<=1.
- Q==1, AUTO_RELOAD=1 and R!=0: Q<=R, stay RUN, Done<=1.
- Q==1, AUTO_RELOAD=1 and R==0: treat as AUTO_RELOAD=0.

Tick, Done and arithmetic rules:
- Tick is ignored in IDLE, HOLD and EXPIRED.
- Stop and Tick in the same cycle: Stop wins, no decrement.
- Done is high exactly one cycle, in the cycle after the expiring edge. Otherwise 0.
- No wrap below zero: Q never goes 0 -> 2^N-1.
- Decrement is N-bit unsigned. No other arithmetic.
- Latency: Start to first possible decrement = 1 cycle, since the state register updates first.

Decomposition:
- Shared package (counter_pkg):
  - State encoding localparams ST_IDLE, ST_RUN, ST_HOLD, ST_EXPIRED (2-bit).
  - Default width constant.
- No internal sub-modules.
- Companion block tick_prescaler (parameter DIV, generates a one-cycle Tick every DIV Clock cycles) is instantiated alongside, not inside.

Test Plan:
1. N=4. Reset; Load D=3; Start; Tick=1 every cycle -> Q 3,2,1,0; Done=1 exactly one cycle after Q reaches 0; state EXPIRED, Busy=0, Q holds 0 under further Ticks.
2. Load D=5, Start, Tick every 4th cycle -> Q decrements only on Tick cycles; expiry after 20 cycles; Done single pulse.
3. Load D=6, Start, 2 Ticks (Q=4), Stop with Tick=1 in the same cycle -> Q stays 4 while Ticks continue, Busy=1. Start -> resumes 3,2,1,0.
4. AUTO_RELOAD=1, Load D=2, Start, Tick every cycle -> Q 2,1,2,1,...; Done pulse every 2 Ticks; Busy stays 1. Stop -> HOLD.
5. Load D=0, Start -> EXPIRED next cycle, Done=1 one cycle, Q=0. Start again -> R=0, Done pulses again, stays EXPIRED.
6. Mid-run (Q=7, RUN): Reset one cycle -> Q=9 (PRESET), IDLE, Done=0, Busy=0. Then Load D=4 with Start in the same cycle -> Q=4, IDLE (Load wins). Start -> RUN.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the loadable down-counter family.
// Holds the controller state encoding and the default counter width.
package counter_pkg;

    localparam int DEFAULT_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HOLD    = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause/resume, optional auto-reload and a one-cycle Done pulse.
// Decrements on qualified Tick pulses from an external prescaler.
module countdown_timer
    import counter_pkg::*;
#(
    parameter int N           = DEFAULT_N,
    parameter int PRESET      = 9,
    parameter int AUTO_RELOAD = 0
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Tick,
    input  logic         Load,
    input  logic [N-1:0] D,
    input  logic         Start,
    input  logic         Stop,
    output logic [N-1:0] Q,
    output logic         Busy,
    output logic         Done
);

    localparam logic [N-1:0] PRESET_V = N'(PRESET);
    localparam logic [N-1:0] ONE      = N'(1);
    localparam logic [N-1:0] ZERO     = '0;

    state_t       state;
    logic [N-1:0] reload;

    // Start is only honoured when Stop is low: Stop wins a simultaneous request.
    logic start_req;
    assign start_req = Start && !Stop;

    assign Busy = (state == ST_RUN) || (state == ST_HOLD);

    // NOTE: all state here is sequential, so every update uses <= to avoid
    // read-after-write races between registers sampled on the same edge.
    always_ff @(posedge Clock) begin
        Done <= 1'b0;
        if (Reset) begin
            Q      <= PRESET_V;
            reload <= PRESET_V;
            state  <= ST_IDLE;
        end else if (Load) begin
            Q      <= D;
            reload <= D;
            state  <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE, ST_HOLD: begin
                    if (start_req) begin
                        if (Q != ZERO) begin
                            state <= ST_RUN;
                        end else begin
                            state <= ST_EXPIRED;
                            Done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (Stop) begin
                        state <= ST_HOLD;
                    end else if (Tick) begin
                        if (Q > ONE) begin
                            Q <= Q - ONE;
                        end else if ((AUTO_RELOAD != 0) && (reload != ZERO)) begin
                            Q    <= reload;
                            Done <= 1'b1;
                        end else begin
                            // Saturate at zero rather than wrapping to all-ones.
                            Q     <= ZERO;
                            state <= ST_EXPIRED;
                            Done  <= 1'b1;
                        end
                    end
                end
                ST_EXPIRED: begin
                    if (start_req) begin
                        if (reload != ZERO) begin
                            Q     <= reload;
                            state <= ST_RUN;
                        end else begin
                            Done <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
